// File: rtl/float7_pkg.sv
// Shared widths, FSM encoding and float7 field helpers for the exponent-align stage.
package float7_pkg;

  localparam int EXP_W     = 3;
  localparam int FRAC_W    = 4;
  localparam int SIG_W     = 5;
  localparam int F7_W      = EXP_W + FRAC_W;
  localparam int MAX_SHIFT = 5;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [EXP_W-1:0] f7_exp(input logic [F7_W-1:0] f);
    return f[F7_W-1 -: EXP_W];
  endfunction

  function automatic logic [FRAC_W-1:0] f7_frac(input logic [F7_W-1:0] f);
    return f[FRAC_W-1:0];
  endfunction

  // Significand with the implicit leading one restored.
  function automatic logic [SIG_W-1:0] f7_sig(input logic [F7_W-1:0] f);
    return {1'b1, f7_frac(f)};
  endfunction

endpackage

// File: rtl/sticky_shr1.sv
// One-bit logical right shift of a significand, folding the lost bit into sticky.
module sticky_shr1
  import float7_pkg::*;
(
  input  logic [SIG_W-1:0] sig,
  input  logic             sticky,
  output logic [SIG_W-1:0] shifted,
  output logic             sticky_next
);

  assign shifted     = {1'b0, sig[SIG_W-1:1]};
  assign sticky_next = sticky | sig[0];

endmodule

// File: rtl/float7_align.sv
// Aligns two float7 operands to the larger exponent, one bit of shift per cycle,
// so the result can feed an equal-exponent adder directly.
module float7_align
  import float7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [F7_W-1:0]  a,
  input  logic [F7_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_o,
  output logic [SIG_W-1:0] ma_o,
  output logic [SIG_W-1:0] mb_o,
  output logic             sticky_o
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              shift_a;
  logic              accept;
  logic [EXP_W-1:0]  ea, eb, diff;
  logic              a_ge;
  logic [CNT_W-1:0]  cnt_load;
  logic [SIG_W-1:0]  shift_src, shifted;
  logic              sticky_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  assign ea       = f7_exp(a);
  assign eb       = f7_exp(b);
  assign a_ge     = (ea >= eb);
  assign diff     = a_ge ? (ea - eb) : (eb - ea);
  // Beyond MAX_SHIFT every significand bit is already gone; stop there.
  assign cnt_load = (CNT_W'(diff) > CNT_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : CNT_W'(diff);

  assign shift_src = shift_a ? ma_o : mb_o;

  sticky_shr1 u_shr (
    .sig         (shift_src),
    .sticky      (sticky_o),
    .shifted     (shifted),
    .sticky_next (sticky_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (cnt_load != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands keep their a/b positions; only the smaller-exponent one moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_o    <= '0;
      ma_o     <= '0;
      mb_o     <= '0;
      sticky_o <= 1'b0;
      cnt      <= '0;
      shift_a  <= 1'b0;
    end else if (accept) begin
      exp_o    <= a_ge ? ea : eb;
      ma_o     <= f7_sig(a);
      mb_o     <= f7_sig(b);
      sticky_o <= 1'b0;
      cnt      <= cnt_load;
      shift_a  <= ~a_ge;
    end else if (state == SHIFT) begin
      if (shift_a) ma_o <= shifted;
      else         mb_o <= shifted;
      sticky_o <= sticky_next;
      cnt      <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_float7_align.sv
// Directed bench for float7_align: hand-computed alignment results, latency,
// backpressure hold and mid-operation reset.
module tb_float7_align;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [6:0] a = '0;
  logic [6:0] b = '0;
  logic       in_ready, out_valid, sticky_o;
  logic [2:0] exp_o;
  logic [4:0] ma_o, mb_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  float7_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_o     (exp_o),
    .ma_o      (ma_o),
    .mb_o      (mb_o),
    .sticky_o  (sticky_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a pair, then count edges (accept edge = 1) until out_valid.
  task automatic send(input string tag, input logic [6:0] va, input logic [6:0] vb,
                      input int lat_exp);
    int lat;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 7'h55; b = 7'h2a;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(lat_exp));
  endtask

  task automatic expect_out(input string tag, input logic [2:0] e, input logic [4:0] ma,
                            input logic [4:0] mb, input logic st);
    chk({tag, ".exp_o"},    32'(exp_o),    32'(e));
    chk({tag, ".ma_o"},     32'(ma_o),     32'(ma));
    chk({tag, ".mb_o"},     32'(mb_o),     32'(mb));
    chk({tag, ".sticky_o"}, 32'(sticky_o), 32'(st));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".idle_ready"}, 32'(in_ready),  32'd1);
    chk({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic seen;

    // Reset values
    #12;
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.exp_o",     32'(exp_o),     32'd0);
    chk("rst.ma_o",      32'(ma_o),      32'd0);
    chk("rst.mb_o",      32'(mb_o),      32'd0);
    chk("rst.sticky_o",  32'(sticky_o),  32'd0);

    // First accept on the first edge after release; equal exponents
    @(negedge clk); rst_n = 1'b1;
    send("eq", 7'b1001000, 7'b1001000, 1);
    expect_out("eq", 3'b100, 5'b11000, 5'b11000, 1'b0);
    take("eq");

    send("d1", 7'b1011000, 7'b1001100, 2);
    expect_out("d1", 3'b101, 5'b11000, 5'b01110, 1'b0);
    take("d1");

    send("d3", 7'b0010001, 7'b1000000, 4);
    expect_out("d3", 3'b100, 5'b00010, 5'b10000, 1'b1);
    take("d3");

    send("sat", 7'b1110000, 7'b0000000, 6);
    expect_out("sat", 3'b111, 5'b10000, 5'b00000, 1'b1);
    take("sat");

    // Backpressure, with b the larger operand so ordering is exercised too
    send("bp", 7'b1001100, 7'b1011000, 2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_out("bp.hold", 3'b101, 5'b01110, 5'b11000, 1'b0);
      chk("bp.in_ready",  32'(in_ready),  32'd0);
      chk("bp.out_valid", 32'(out_valid), 32'd1);
    end
    take("bp");
    send("bp.next", 7'b1001000, 7'b1001000, 1);
    expect_out("bp.next", 3'b100, 5'b11000, 5'b11000, 1'b0);
    take("bp.next");

    // Reset in the middle of SHIFT abandons the pair
    a = 7'b0010001; b = 7'b1000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.in_ready",  32'(in_ready),  32'd1);
    chk("mid.ma_o",      32'(ma_o),      32'd0);
    chk("mid.sticky_o",  32'(sticky_o),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("mid.no_stale", 32'(seen), 32'd0);
    send("post", 7'b1110000, 7'b0000000, 6);
    expect_out("post", 3'b111, 5'b10000, 5'b00000, 1'b1);
    take("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/float7_align.md
FLOAT7_ALIGN -- requirements
Module: float7_align

Interface
REQ-001 Parameters: none; field widths and shift limit come from the shared package.
REQ-002 Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand pair a/b is offered.
REQ-006 in_ready  output  1  block can accept a pair; high only in IDLE.
REQ-007 a  input  7  float7 operand: [6:4] exponent, [3:0] fraction, implicit leading 1, unsigned.
REQ-008 b  input  7  float7 operand, same format as a.
REQ-009 out_valid  output  1  aligned result is presented; high only in DONE.
REQ-010 out_ready  input  1  downstream equal-exponent adder consumes the result.
REQ-011 exp_o  output  3  common exponent, max(ea, eb).
REQ-012 ma_o  output  5  aligned significand of a: hidden bit plus fraction, after any right shift.
REQ-013 mb_o  output  5  aligned significand of b, same encoding as ma_o.
REQ-014 sticky_o  output  1  OR of every bit shifted out of the smaller operand.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 Accept rule: a pair is accepted on a cycle where in_valid and in_ready are both high.
REQ-017 On accept:
- register exp = max(ea, eb);
- register sa = {1, a[3:0]} and sb = {1, b[3:0]};
- compute d = |ea - eb| and load cnt = min(d, 5);
- clear sticky;
- go to SHIFT if cnt > 0, else go to DONE.
REQ-018 In SHIFT, each cycle:
- the significand with the smaller exponent shifts right by 1 with zero fill;
- sticky ORs in the bit shifted out;
- cnt decrements;
- on the cycle cnt goes 1 -> 0, go to DONE.
REQ-019 If ea == eb, neither significand shifts; ties are not shifted.
REQ-020 Saturation: if d >= 5, exactly 5 shifts occur, the shifted significand ends at 00000 and sticky ends at 1.
REQ-021 Latency: out_valid rises 1 + min(d, 5) cycles after the accept edge; d = 0 gives 1 cycle, d >= 5 gives 6 cycles.
REQ-022 Output ordering: ma_o always belongs to a and mb_o to b; operands are never swapped.
REQ-023 In DONE, exp_o, ma_o, mb_o and sticky_o hold stable until out_ready is high.
REQ-024 On the out_valid and out_ready handshake the FSM goes to IDLE; the next accept is possible the following cycle.
REQ-025 Throughput is one pair per 2 + min(d, 5) cycles with no backpressure.
REQ-026 in_ready is decoded combinationally from state == IDLE.
REQ-027 Inputs a and b are ignored outside the accept cycle.
REQ-028 Outputs are undriven-by-inputs: exp_o, ma_o, mb_o and sticky_o are driven from registers only.

Reset
REQ-029 While rst_n is low:
- state = IDLE;
- out_valid = 0 and in_ready = 1;
- exp_o = 0, ma_o = 0, mb_o = 0, sticky_o = 0, cnt = 0.
REQ-030 Reset asserted during SHIFT or DONE SHALL abandon the pair; no out_valid follows release.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package float7_pkg SHALL hold:
- EXP_W = 3, FRAC_W = 4, SIG_W = 5, MAX_SHIFT = 5;
- the FSM state enum (IDLE, SHIFT, DONE);
- the float7 field-slice helpers.
REQ-033 One sub-module, sticky_shr1, SHALL perform the combinational 1-bit right shift of SIG_W bits with sticky accumulation.
REQ-034 Result fields SHALL connect directly to the equal-exponent adder inputs:
- exp_o drives its ea;
- ma_o and mb_o replace its {01, frac} construction.

Verification
REQ-035 Equal exponents: a = 1001000, b = 1001000 -> out_valid 1 cycle after accept; exp_o = 100, ma_o = 11000, mb_o = 11000, sticky_o = 0.
REQ-036 Difference of 1: a = 1011000, b = 1001100 -> latency 2; exp_o = 101, ma_o = 11000, mb_o = 01110, sticky_o = 0.
REQ-037 Difference of 3 with lost bits: a = 0010001, b = 1000000 -> latency 4; exp_o = 100, ma_o = 00010, mb_o = 10000, sticky_o = 1.
REQ-038 Saturation: a = 1110000, b = 0000000 -> latency 6; exp_o = 111, ma_o = 10000, mb_o = 00000, sticky_o = 1.
REQ-039 Backpressure: hold out_ready = 0 for 3 cycles in DONE -> outputs stable and in_ready = 0; after the handshake, in_ready = 1 the next cycle and a new pair is accepted.
REQ-040 Reset mid-operation: rst_n pulsed low during SHIFT of the REQ-037 pair -> out_valid = 0 immediately; in_ready = 1; no stale result appears after release.
